// File: rtl/vic20_pkg.sv
// Shared VIC-20 definitions: default BASIC pointer locations and the
// program-upload state encoding.
package vic20_pkg;

  localparam logic [15:0] PTR_START_DEFAULT = 16'h002B;
  localparam logic [15:0] PTR_END_DEFAULT   = 16'h002D;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_SL  = 4'd1,
    RD_SH  = 4'd2,
    RD_EL  = 4'd3,
    RD_EH  = 4'd4,
    CHECK  = 4'd5,
    HDR_L  = 4'd6,
    HDR_H  = 4'd7,
    RD_DAT = 4'd8,
    SEND   = 4'd9,
    FIN    = 4'd10
  } upl_state_t;

endpackage

// File: rtl/prg_upload.sv
// Streams a resident BASIC program out of memory: two header bytes holding
// the load address, followed by every byte from the start to the end pointer.
module prg_upload
  import vic20_pkg::*;
#(
  parameter logic [15:0] PTR_START = PTR_START_DEFAULT,
  parameter logic [15:0] PTR_END   = PTR_END_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  upl_data,
  output logic        upl_valid,
  input  logic        upl_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  upl_state_t  state;
  logic [15:0] start_ptr;
  logic [15:0] end_ptr;
  logic [15:0] cur;
  logic [15:0] cur_next;
  logic        read_done;
  logic        accepted;

  assign cur_next  = cur + 16'd1;
  assign read_done = mem_rd && mem_ack;
  assign accepted  = upl_valid && upl_ready;
  assign busy      = (state != IDLE);

  // Each read state spends one cycle with mem_rd low after its address is set,
  // so mem_rd always drops the cycle after an ack and never overlaps upl_valid.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= 16'h0000;
      mem_rd    <= 1'b0;
      upl_data  <= 8'h00;
      upl_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      start_ptr <= 16'h0000;
      end_ptr   <= 16'h0000;
      cur       <= 16'h0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr <= PTR_START;
            state    <= RD_SL;
          end
        end
        RD_SL, RD_SH, RD_EL, RD_EH, RD_DAT: begin
          if (read_done) begin
            mem_rd <= 1'b0;
            case (state)
              RD_SL: begin
                start_ptr[7:0] <= mem_dout;
                mem_addr       <= PTR_START + 16'd1;
                state          <= RD_SH;
              end
              RD_SH: begin
                start_ptr[15:8] <= mem_dout;
                mem_addr        <= PTR_END;
                state           <= RD_EL;
              end
              RD_EL: begin
                end_ptr[7:0] <= mem_dout;
                mem_addr     <= PTR_END + 16'd1;
                state        <= RD_EH;
              end
              RD_EH: begin
                end_ptr[15:8] <= mem_dout;
                state         <= CHECK;
              end
              default: begin
                upl_data  <= mem_dout;
                upl_valid <= 1'b1;
                state     <= SEND;
              end
            endcase
          end else begin
            mem_rd <= 1'b1;
          end
        end
        CHECK: begin
          if (end_ptr < start_ptr) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            upl_data  <= start_ptr[7:0];
            upl_valid <= 1'b1;
            state     <= HDR_L;
          end
        end
        HDR_L: begin
          if (accepted) begin
            upl_data <= start_ptr[15:8];
            state    <= HDR_H;
          end
        end
        HDR_H: begin
          if (accepted) begin
            upl_valid <= 1'b0;
            cur       <= start_ptr;
            if (start_ptr == end_ptr) begin
              state <= FIN;
            end else begin
              mem_addr <= start_ptr;
              state    <= RD_DAT;
            end
          end
        end
        SEND: begin
          if (accepted) begin
            upl_valid <= 1'b0;
            cur       <= cur_next;
            if (cur_next == end_ptr) begin
              state <= FIN;
            end else begin
              mem_addr <= cur_next;
              state    <= RD_DAT;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_upload.sv
// Bench for prg_upload: a memory model with random ack latency, a random-ready
// sink, and an expected stream built from the memory image and the pointers.
module tb_prg_upload;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  upl_data;
  logic        upl_valid;
  logic        upl_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  prg_upload dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack),
    .mem_dout (mem_dout),
    .upl_data (upl_data),
    .upl_valid(upl_valid),
    .upl_ready(upl_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       tag;
    logic [15:0] sp;
    logic [15:0] ep;
    int          rdy_pct;
    int          max_lat;
    bit          exp_err;
    int          exp_len;
  } vec_t;

  logic [7:0] mem [0:65535];
  logic [7:0] rcv_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt, err_cnt, read_cnt, overlap_cnt, stall_viol, rd_viol, busy_err;
  int ready_pct = 100;
  int max_lat = 1;
  int lat_cnt = -1;
  logic       p_valid = 1'b0, p_ready = 1'b0, p_rd = 1'b0, p_ack = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic [15:0] p_addr = 16'h0000;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Memory responder, sink and protocol monitor all act on the falling edge,
  // so what they see is exactly what the DUT samples at the next rising edge.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        mem_ack = 1'b0;
        upl_ready = 1'b0;
        lat_cnt = -1;
        p_valid = 1'b0;
        p_rd = 1'b0;
        p_ack = 1'b0;
        continue;
      end
      if (p_valid && !p_ready && (!upl_valid || upl_data !== p_data)) stall_viol++;
      if (p_rd && !p_ack && (!mem_rd || mem_addr !== p_addr)) rd_viol++;
      if (mem_rd && upl_valid) overlap_cnt++;
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        if (busy) busy_err++;
      end
      upl_ready = ($urandom_range(99, 0) < ready_pct);
      mem_ack = 1'b0;
      if (mem_rd && !p_ack) begin
        if (lat_cnt < 0) lat_cnt = $urandom_range(max_lat, 1) - 1;
        if (lat_cnt == 0) begin
          mem_ack = 1'b1;
          mem_dout = mem[mem_addr];
          read_cnt++;
          lat_cnt = -1;
        end else begin
          lat_cnt--;
        end
      end
      if (upl_valid && upl_ready) rcv_q.push_back(upl_data);
      p_valid = upl_valid;
      p_ready = upl_ready;
      p_data = upl_data;
      p_rd = mem_rd;
      p_ack = mem_ack;
      p_addr = mem_addr;
    end
  end

  task automatic apply_stimulus(input logic [15:0] sp, input logic [15:0] ep,
                                input int rdy, input int lat);
    mem[16'h002B] = sp[7:0];
    mem[16'h002C] = sp[15:8];
    mem[16'h002D] = ep[7:0];
    mem[16'h002E] = ep[15:8];
    ready_pct = rdy;
    max_lat = lat;
    rcv_q.delete();
    done_cnt = 0; err_cnt = 0; read_cnt = 0;
    overlap_cnt = 0; stall_viol = 0; rd_viol = 0; busy_err = 0;
    @(negedge clk_sys);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic finish_upload(input string tag, input logic [15:0] sp, input logic [15:0] ep,
                               input bit exp_err);
    logic [7:0] exp_q[$];
    logic [15:0] a;
    int n;
    for (int i = 0; i < 5000 && (done_cnt + err_cnt) == 0; i++) @(negedge clk_sys);
    repeat (4) @(negedge clk_sys);
    check_output({tag, " finished"}, int'((done_cnt + err_cnt) > 0), 1);
    if (!exp_err) begin
      exp_q.push_back(sp[7:0]);
      exp_q.push_back(sp[15:8]);
      for (a = sp; a != ep; a++) exp_q.push_back(mem[a]);
    end
    check_output({tag, " byte count"}, rcv_q.size(), exp_q.size());
    n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_output($sformatf("%s byte %0d", tag, i), rcv_q[i], exp_q[i]);
    check_output({tag, " done pulses"}, done_cnt, exp_err ? 0 : 1);
    check_output({tag, " err pulses"}, err_cnt, exp_err ? 1 : 0);
    check_output({tag, " reads"}, read_cnt, exp_err ? 4 : 4 + int'(ep - sp));
    check_output({tag, " rd/valid overlap"}, overlap_cnt, 0);
    check_output({tag, " stall stability"}, stall_viol, 0);
    check_output({tag, " read hold"}, rd_viol, 0);
    check_output({tag, " busy at err"}, busy_err, 0);
    check_output({tag, " busy at end"}, int'(busy), 0);
  endtask

  vec_t vecs[8];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1001] = 8'hAA;
    mem[16'h1002] = 8'hBB;
    mem[16'h1003] = 8'hCC;

    vecs[0] = '{"normal",     16'h1001, 16'h1004, 100, 1, 1'b0, 5};
    vecs[1] = '{"zero",       16'h1001, 16'h1001, 100, 1, 1'b0, 2};
    vecs[2] = '{"error",      16'h1201, 16'h1001, 100, 1, 1'b1, 0};
    vecs[3] = '{"backpress",  16'h1001, 16'h1004,  50, 5, 1'b0, 5};
    for (int i = 4; i < 8; i++) begin
      logic [15:0] rs;
      logic [15:0] rl;
      rs = 16'($urandom_range(16'hF000, 16'h2000));
      rl = 16'($urandom_range(20, 0));
      vecs[i] = '{$sformatf("rand%0d", i), rs, rs + rl, $urandom_range(90, 30), 5, 1'b0, int'(rl) + 2};
    end

    repeat (3) @(negedge clk_sys);
    #1;
    check_output("reset mem_rd", int'(mem_rd), 0);
    check_output("reset upl_valid", int'(upl_valid), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset mem_addr", int'(mem_addr), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].sp, vecs[i].ep, vecs[i].rdy_pct, vecs[i].max_lat);
      finish_upload(vecs[i].tag, vecs[i].sp, vecs[i].ep, vecs[i].exp_err);
      check_output({vecs[i].tag, " table length"}, rcv_q.size(), vecs[i].exp_len);
    end

    // Reset right after the third byte is taken, then a clean upload.
    apply_stimulus(16'h1001, 16'h1004, 100, 3);
    for (int i = 0; i < 2000 && rcv_q.size() < 3; i++) @(negedge clk_sys);
    check_output("rst reached 3 bytes", rcv_q.size(), 3);
    @(posedge clk_sys);
    #1;
    reset = 1'b1;
    #1;
    check_output("rst mem_rd", int'(mem_rd), 0);
    check_output("rst upl_valid", int'(upl_valid), 0);
    check_output("rst busy", int'(busy), 0);
    check_output("rst done", int'(done), 0);
    check_output("rst err", int'(err), 0);
    check_output("rst upl_data", int'(upl_data), 0);
    repeat (3) @(negedge clk_sys);
    check_output("rst no done", done_cnt, 0);
    reset = 1'b0;
    apply_stimulus(16'h1001, 16'h1004, 100, 2);
    finish_upload("after_rst", 16'h1001, 16'h1004, 1'b0);

    // A start pulse while a data byte is being offered must be ignored.
    apply_stimulus(16'h1001, 16'h1004, 70, 2);
    for (int i = 0; i < 2000 && !(rcv_q.size() >= 3 && upl_valid); i++) @(negedge clk_sys);
    check_output("busy_start in send", int'(upl_valid && busy), 1);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    finish_upload("busy_start", 16'h1001, 16'h1004, 1'b0);
    repeat (20) @(negedge clk_sys);
    check_output("busy_start no restart", int'(busy), 0);
    check_output("busy_start bytes stay", rcv_q.size(), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prg_upload.md
PRG_UPLOAD -- requirements
Module: prg_upload

Interface
REQ-001 Parameter PTR_START, default 16'h002B, address of the BASIC program-start pointer (lo, hi at +1).
REQ-002 Parameter PTR_END, default 16'h002D, address of the BASIC variable-start pointer, i.e. the program end, exclusive (lo, hi at +1).
REQ-003 One clock and one reset: clk_sys is the single clock; reset is asynchronous and active-high.
REQ-004 Port clk_sys, input, 1, system clock.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port start, input, 1, single-cycle request to begin an upload.
REQ-007 Port mem_addr, output, 16, memory read address.
REQ-008 Port mem_rd, output, 1, read request, held until acknowledged.
REQ-009 Port mem_ack, input, 1, one-cycle pulse; mem_dout is valid in that cycle.
REQ-010 Port mem_dout, input, 8, memory read data.
REQ-011 Port upl_data, output, 8, upload byte.
REQ-012 Port upl_valid, output, 1, upl_data is valid.
REQ-013 Port upl_ready, input, 1, the sink accepts the byte this cycle.
REQ-014 Port busy, output, 1, an upload is in progress.
REQ-015 Port done, output, 1, one-cycle pulse at the end of a successful upload.
REQ-016 Port err, output, 1, one-cycle pulse when the end pointer is below the start pointer.

Function
REQ-017 The FSM states SHALL be IDLE, RD_SL, RD_SH, RD_EL, RD_EH, CHECK, HDR_L, HDR_H, RD_DAT, SEND, FIN.
REQ-018 IDLE SHALL go to RD_SL on start; start is ignored in every other state.
REQ-019 RD_SL, RD_SH, RD_EL and RD_EH SHALL each read PTR_START, PTR_START+1, PTR_END and PTR_END+1 respectively, and advance on mem_ack.
REQ-020 A memory read SHALL assert mem_rd with mem_addr stable until the cycle of mem_ack; mem_rd SHALL deassert the cycle after.
REQ-021 CHECK SHALL take one cycle: if end < start (unsigned 16-bit), pulse err and go to IDLE; otherwise go to HDR_L.
REQ-022 HDR_L and HDR_H SHALL present start[7:0] and then start[15:8] on the stream.
REQ-023 After HDR_H, cur SHALL load start; go to FIN if cur == end, else to RD_DAT.
REQ-024 RD_DAT SHALL read mem[cur] and latch the data on mem_ack, then go to SEND.
REQ-025 SEND SHALL present the latched byte; on acceptance cur increments (16-bit wrap), and the FSM goes to FIN if the incremented cur == end, else to RD_DAT.
REQ-026 The stream SHALL follow valid/ready:
- a byte is accepted when upl_valid & upl_ready;
- upl_data is held stable while upl_valid & !upl_ready;
- upl_valid never drops without acceptance.
REQ-027 upl_valid MAY assert in the cycle of state entry; at most one byte SHALL be accepted per cycle.
REQ-028 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 A zero-length program (end == start) SHALL emit exactly the two header bytes, then done.
REQ-031 Total bytes emitted SHALL equal 2 + (end - start).
REQ-032 mem_rd and upl_valid SHALL never be asserted in the same cycle.

Reset
REQ-033 On reset, asynchronously:
- state goes to IDLE;
- mem_rd, upl_valid, busy, done and err go to 0;
- mem_addr, upl_data, cur, start and end registers go to 16'h0000 / 8'h00.
REQ-034 Reset mid-upload SHALL abandon the transfer with no done or err pulse; a new start is honoured the first cycle after reset deasserts.

Structure
REQ-035 The state enum and the default pointer constants (16'h002B, 16'h002D) SHALL live in the shared package vic20_pkg.
REQ-036 The block SHALL be a single FSM module with no sub-modules; the datapath is the start, end and cur registers plus one byte register.

Verification
REQ-037 Normal upload: mem[2B..2E] = 01 10 04 10, mem[1001..1003] = AA BB CC, ready always high -> stream 01 10 AA BB CC, then one done pulse.
REQ-038 Zero length: start = end = 1001 -> stream 01 10 only, then done; no data read issued.
REQ-039 Error: start = 1201, end = 1001 -> err pulse, no stream bytes, busy low within 6 cycles.
REQ-040 Backpressure: random upl_ready with mem_ack latency of 1 to 5 cycles -> same byte sequence as REQ-037, upl_data stable while stalled, no mem_rd/upl_valid overlap.
REQ-041 Reset mid-transfer: assert reset after the 3rd accepted byte -> all outputs 0 immediately, no done; a following start gives a complete correct upload.
REQ-042 Start while busy: pulse start during SEND -> ignored; the byte count is unchanged.
